// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader
//   Serial configuration loader for the bidirectional fabric. Hunts for a
//   SYNC byte, then takes a 4-bit target address, the payload (36 bits for a
//   routing block, 6 bits for an IO block) and optionally an even-parity bit.
//   Good frames are committed into the addressed output slice. Bad frames are
//   dropped, and the live configuration is left untouched.
//
//   Optional feature macro: CFG_PARITY_EN
//     defined   : a trailing parity bit is expected and checked (PAR state)
//     undefined : no parity bit; commit happens on the last payload bit
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   cfg_sdi    serial data, MSB first
//   cfg_valid  qualifies cfg_sdi; low cycles stall the whole loader
//   cfg_brb    routing configs, target i at [36*i +: 36]
//   cfg_iob    IO configs, target j at [6*j +: 6]
//   cfg_busy   high whenever a frame is in progress (state != HUNT)
//   cfg_done   one-cycle pulse on commit
//   cfg_err    one-cycle pulse on a discarded frame
module fabric_cfg_loader #(
    parameter int         N_BRB = 2,
    parameter int         N_IOB = 2,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_sdi,
    input  logic                cfg_valid,
    output logic [36*N_BRB-1:0] cfg_brb,
    output logic [6*N_IOB-1:0]  cfg_iob,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        HUNT,
        ADDR,
        DATA
`ifdef CFG_PARITY_EN
        , PAR
`endif
    } state_e;

    state_e              state_q;
    logic [6:0]          sync_q;     // last 7 bits; the 8th is the live cfg_sdi
    logic [3:0]          addr_q;
    logic [5:0]          cnt_q;
    logic                brb_sel_q;  // 1: payload is 36 bits, 0: 6 bits
    logic [35:0]         shadow_q;
`ifdef CFG_PARITY_EN
    logic                par_q;      // running XOR of address and payload
`endif
    logic [36*N_BRB-1:0] brb_q;
    logic [6*N_IOB-1:0]  iob_q;
    logic                busy_q, done_q, err_q;

    logic [7:0]  sync_d;
    logic [3:0]  addr_d;
    logic [35:0] shadow_d;
    logic        addr_bad;
    logic        last_bit;

    assign sync_d   = {sync_q, cfg_sdi};
    assign addr_d   = {addr_q[2:0], cfg_sdi};
    assign shadow_d = {shadow_q[34:0], cfg_sdi};
    assign addr_bad = 32'(addr_d) >= N_BRB + N_IOB;
    assign last_bit = cnt_q == (brb_sel_q ? 6'd35 : 6'd5);

    function automatic logic [36*N_BRB-1:0] put_brb(input logic [36*N_BRB-1:0] cur,
                                                    input logic [3:0] a,
                                                    input logic [35:0] v);
        logic [36*N_BRB-1:0] r;
        r = cur;
        for (int i = 0; i < N_BRB; i++)
            if (a == 4'(i)) r[36*i +: 36] = v;
        return r;
    endfunction

    function automatic logic [6*N_IOB-1:0] put_iob(input logic [6*N_IOB-1:0] cur,
                                                   input logic [3:0] a,
                                                   input logic [5:0] v);
        logic [6*N_IOB-1:0] r;
        r = cur;
        for (int j = 0; j < N_IOB; j++)
            if (a == 4'(N_BRB + j)) r[6*j +: 6] = v;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            sync_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            brb_sel_q <= 1'b0;
            shadow_q  <= '0;
`ifdef CFG_PARITY_EN
            par_q     <= 1'b0;
`endif
            brb_q     <= '0;
            iob_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (cfg_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (sync_d == SYNC) begin
                            // Clearing here means the register is empty on the
                            // next return to HUNT, so frames never overlap.
                            sync_q  <= '0;
                            cnt_q   <= '0;
`ifdef CFG_PARITY_EN
                            par_q   <= 1'b0;
`endif
                            busy_q  <= 1'b1;
                            state_q <= ADDR;
                        end else begin
                            sync_q <= sync_d[6:0];
                        end
                    end
                    ADDR: begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 6'd1;
`ifdef CFG_PARITY_EN
                        par_q  <= par_q ^ cfg_sdi;
`endif
                        if (cnt_q == 6'd3) begin
                            cnt_q <= '0;
                            if (addr_bad) begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= HUNT;
                            end else begin
                                brb_sel_q <= 32'(addr_d) < N_BRB;
                                state_q   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        shadow_q <= shadow_d;
                        cnt_q    <= cnt_q + 6'd1;
`ifdef CFG_PARITY_EN
                        par_q    <= par_q ^ cfg_sdi;
                        if (last_bit) state_q <= PAR;
`else
                        if (last_bit) begin
                            if (brb_sel_q) brb_q <= put_brb(brb_q, addr_q, shadow_d);
                            else           iob_q <= put_iob(iob_q, addr_q, shadow_d[5:0]);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= HUNT;
                        end
`endif
                    end
`ifdef CFG_PARITY_EN
                    PAR: begin
                        if (par_q ^ cfg_sdi) begin
                            err_q <= 1'b1;
                        end else begin
                            if (brb_sel_q) brb_q <= put_brb(brb_q, addr_q, shadow_q);
                            else           iob_q <= put_iob(iob_q, addr_q, shadow_q[5:0]);
                            done_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= HUNT;
                    end
`endif
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign cfg_brb  = brb_q;
    assign cfg_iob  = iob_q;
    assign cfg_busy = busy_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

endmodule
